// File: rtl/riscv_m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: Funct3 encodings,
// controller state encoding and the default datapath width.
package riscv_m_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            next_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  // Trial subtraction; the remainder stays below the divisor so XLEN bits suffice
  always_comb begin
    shifted  = {rem, next_bit};
    diff     = shifted[XLEN-1:0] - divisor;
    q_bit    = (shifted >= {1'b0, divisor});
    rem_next = q_bit ? diff : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. Operands are captured as magnitudes
// plus sign flags on acceptance; one bit is processed per cycle and the sign
// fix-up / result select happens on the final iteration edge.
// Handshake: Start is sampled only in IDLE; Busy is high from the accepting
// edge until the edge after the one-cycle Done pulse; WD/A3 hold until the
// next Done.
module mul_div_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  input  logic [4:0]      Rd,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] WD,
  output logic [4:0]      A3,
  output logic            RegWrite,
  output state_t          state_dbg
);

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  state_t          state, state_nx;
  logic [5:0]      cnt;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            neg_a, neg_b, early;
  logic [XLEN-1:0] opnd, acc_hi, acc_lo;

  logic            rs1_s, rs2_s, is_div, div_zero, ovf, accept, last;
  logic [XLEN-1:0] mag_a, mag_b, early_val;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] div_rem, hi_nx, lo_nx, q_fix, r_fix, result;
  logic            div_q;
  logic [2*XLEN-1:0] prod_fix;

  assign accept    = (state == S_IDLE) && Start;
  assign last      = (cnt == 6'(XLEN-1));
  assign state_dbg = state;

  // Operand signedness and early-exit detection for the incoming request
  always_comb begin
    rs1_s  = 1'b0;
    rs2_s  = 1'b0;
    is_div = 1'b0;
    case (Funct3)
      F3_MUL:    ;
      F3_MULH:   begin rs1_s = 1'b1; rs2_s = 1'b1; end
      F3_MULHSU: rs1_s = 1'b1;
      F3_MULHU:  ;
      F3_DIV:    begin is_div = 1'b1; rs1_s = 1'b1; rs2_s = 1'b1; end
      F3_DIVU:   is_div = 1'b1;
      F3_REM:    begin is_div = 1'b1; rs1_s = 1'b1; rs2_s = 1'b1; end
      F3_REMU:   is_div = 1'b1;
      default:   ;
    endcase
    mag_a     = (rs1_s && RD1[XLEN-1]) ? -RD1 : RD1;
    mag_b     = (rs2_s && RD2[XLEN-1]) ? -RD2 : RD2;
    div_zero  = is_div && (RD2 == '0);
    ovf       = is_div && rs1_s && (RD1 == MIN_NEG) && (RD2 == ALL_ONES);
    if (div_zero) early_val = Funct3[1] ? RD1 : ALL_ONES;
    else          early_val = Funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration of shift-add multiply or restoring divide, plus final fix-up
  always_comb begin
    mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {XLEN{1'b0}})};
    if (f3_q[2]) begin
      hi_nx = div_rem;
      lo_nx = {acc_lo[XLEN-2:0], div_q};
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
    prod_fix = (neg_a ^ neg_b) ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
    q_fix    = (neg_a ^ neg_b) ? -lo_nx : lo_nx;
    r_fix    = neg_a ? -hi_nx : hi_nx;
    if (f3_q[2])              result = f3_q[1] ? r_fix : q_fix;
    else if (f3_q == F3_MUL)  result = prod_fix[XLEN-1:0];
    else                      result = prod_fix[2*XLEN-1:XLEN];
  end

  div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (acc_hi),
    .next_bit (acc_lo[XLEN-1]),
    .divisor  (opnd),
    .rem_next (div_rem),
    .q_bit    (div_q)
  );

  // Controller state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (Start) state_nx = S_CALC;
      S_CALC:  if (early || last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state and the registered destination
  always_comb begin
    Busy     = (state != S_IDLE);
    Done     = (state == S_DONE);
    RegWrite = Done && (A3 != 5'd0);
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt    <= '0;
      f3_q   <= '0;
      rd_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      early  <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      WD     <= '0;
      A3     <= '0;
    end else if (accept) begin
      cnt    <= '0;
      f3_q   <= Funct3;
      rd_q   <= Rd;
      neg_a  <= rs1_s && RD1[XLEN-1];
      neg_b  <= rs2_s && RD2[XLEN-1];
      early  <= div_zero || ovf;
      opnd   <= is_div ? mag_b : mag_a;
      acc_hi <= '0;
      if (div_zero || ovf) acc_lo <= early_val;
      else                 acc_lo <= is_div ? mag_a : mag_b;
    end else if (state == S_CALC) begin
      cnt    <= cnt + 6'd1;
      acc_hi <= hi_nx;
      acc_lo <= lo_nx;
      if (early) begin
        WD <= acc_lo;
        A3 <= rd_q;
      end else if (last) begin
        WD <= result;
        A3 <= rd_q;
      end
    end
  end

endmodule
